// File: rtl/keypad_emulator_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared constants for the 4x4 keypad emulator: FSM state codes, keycode
// field positions, idle row pattern and the bounce LFSR seed/taps.
// Optional feature macro used by the design: RANDOM_BOUNCE_EN.
// ---------------------------------------------------------------------------
package keypad_pkg;

    // FSM state codes (plain constants so older tools can consume them).
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_BOUNCE_IN  = 3'd1;
    localparam state_t ST_HOLD       = 3'd2;
    localparam state_t ST_BOUNCE_OUT = 3'd3;
    localparam state_t ST_GAP        = 3'd4;

    // Keycode layout: [3:2] row index, [1:0] column index.
    localparam int KEY_ROW_HI = 3;
    localparam int KEY_ROW_LO = 2;
    localparam int KEY_COL_HI = 1;
    localparam int KEY_COL_LO = 0;

    // Row bus is active-low; nothing pressed means all ones.
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form: feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// ---------------------------------------------------------------------------
// keypad_emulator_if
// Groups the press-request handshake, the scan matrix lines and the status
// outputs of the keypad emulator.
//   req_valid/req_ready/req_keycode : press request handshake
//   col  : column drive from the scanner (active-low)
//   row  : row return to the scanner (active-low, idle 4'b1111)
//   contact/busy/done : simulated switch closure and status
// master = request source + scanner side, slave = emulator.
// ---------------------------------------------------------------------------
interface keypad_emulator_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_keycode;
    logic [3:0] col;
    logic [3:0] row;
    logic       contact;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_keycode, col,
        input  req_ready, row, contact, busy, done
    );

    modport slave (
        input  req_valid, req_keycode, col,
        output req_ready, row, contact, busy, done
    );
endinterface

// File: rtl/keypad_emulator_lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8
// 8-bit maximal-length LFSR (x^8+x^6+x^5+x^4+1) used to randomise bounce
// phase lengths. Only compiled when RANDOM_BOUNCE_EN is defined.
//   clock, reset : clock and asynchronous active-high reset (loads LFSR_SEED)
//   en_i         : advance one step
//   load_i       : synchronous load of seed_i (takes priority over en_i)
//   seed_i       : value for load_i
//   state_o      : current register contents
// ---------------------------------------------------------------------------
`ifdef RANDOM_BOUNCE_EN
module lfsr8
    import keypad_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LFSR_SEED;
        end else if (load_i) begin
            state_q <= seed_i;
        end else if (en_i) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule
`endif

// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
// Passive 4x4 keypad end of a row/column scan interface. A press request is
// accepted over a valid/ready handshake; the latched key then goes through a
// timed contact envelope (bounce in, hold, bounce out, release gap) and the
// row lines answer the scanner's column drive while the contact is closed.
//
// Ports:
//   clock : system clock
//   reset : asynchronous active-high reset
//   bus   : keypad_emulator_if.slave (req_valid/req_ready/req_keycode,
//           col in, row out, contact/busy/done status)
//
// Parameters: HOLD_CYCLES, BOUNCE_TOGGLES (even, 0 = no bounce),
//             BOUNCE_PERIOD, GAP_CYCLES.
// Macro RANDOM_BOUNCE_EN: bounce phase lengths become
//   1 + (lfsr[3:0] mod BOUNCE_PERIOD), LFSR stepped at every phase start.
// ---------------------------------------------------------------------------
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1000,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_PERIOD  = 16,
    parameter int GAP_CYCLES     = 200
)
(
    input  logic               clock,
    input  logic               reset,
    keypad_emulator_if.slave   bus
);

    localparam int MAX_CNT = max3(HOLD_CYCLES, GAP_CYCLES, BOUNCE_PERIOD);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int PH_W    = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BOUNCE_TOGGLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [3:0]        key_q, key_d;
    logic              done_q, done_d;
    logic              phase_start;   // a bounce phase begins next cycle
    logic [CNT_W-1:0]  cur_len;       // length of the bounce phase in progress
    logic              contact_w;
    logic [3:0]        row_w;

    // -----------------------------------------------------------------------
    // Bounce phase length source
    // -----------------------------------------------------------------------
`ifdef RANDOM_BOUNCE_EN
    logic [7:0]       lfsr_w;
    logic [CNT_W-1:0] phase_len_q, phase_len_d;
    logic [3:0]       unused_lfsr_hi;

    lfsr8 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .en_i    (phase_start),
        .load_i  (1'b0),
        .seed_i  (LFSR_SEED),
        .state_o (lfsr_w)
    );

    // Length is taken from the LFSR value present when the phase starts; the
    // LFSR steps on that same edge so the next phase sees a fresh value.
    assign phase_len_d = phase_start
                       ? CNT_W'(1 + (int'(lfsr_w[3:0]) % BOUNCE_PERIOD))
                       : phase_len_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_len_q <= '0;
        end else begin
            phase_len_q <= phase_len_d;
        end
    end

    assign cur_len        = phase_len_q;
    assign unused_lfsr_hi = lfsr_w[7:4];
`else
    logic unused_phase_start;

    assign cur_len            = CNT_W'(BOUNCE_PERIOD);
    assign unused_phase_start = phase_start;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        cyc_d       = cyc_q;
        phase_d     = phase_q;
        key_d       = key_q;
        done_d      = 1'b0;
        phase_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    key_d   = bus.req_keycode;
                    cyc_d   = '0;
                    phase_d = '0;
                    if (BOUNCE_TOGGLES == 0) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d     = ST_BOUNCE_IN;
                        phase_start = 1'b1;
                    end
                end
            end

            ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
                if (cyc_q == cur_len - CNT_W'(1)) begin
                    cyc_d = '0;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        state_d = (state_q == ST_BOUNCE_IN) ? ST_HOLD : ST_GAP;
                    end else begin
                        phase_d     = phase_q + PH_W'(1);
                        phase_start = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (cyc_q == HOLD_LAST) begin
                    cyc_d   = '0;
                    phase_d = '0;
                    if (BOUNCE_TOGGLES == 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d     = ST_BOUNCE_OUT;
                        phase_start = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cyc_q == GAP_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            phase_q <= '0;
            key_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            cyc_q   <= cyc_d;
            phase_q <= phase_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Contact envelope and row response
    // -----------------------------------------------------------------------
    // Derived from state alone so that reset opens the contact (and releases
    // the row lines) without waiting for a clock edge.
    always_comb begin
        contact_w = 1'b0;
        case (state_q)
            ST_BOUNCE_IN:  contact_w = ~phase_q[0];  // closed on even phases
            ST_HOLD:       contact_w = 1'b1;
            ST_BOUNCE_OUT: contact_w = phase_q[0];   // open on even phases
            default:       contact_w = 1'b0;
        endcase
    end

    // A closed switch shorts its row to its column: the row goes low only
    // while the scanner is driving that key's column low.
    always_comb begin
        row_w = ROW_IDLE;
        if (contact_w && !bus.col[key_q[KEY_COL_HI:KEY_COL_LO]]) begin
            row_w[key_q[KEY_ROW_HI:KEY_ROW_LO]] = 1'b0;
        end
    end

    assign bus.row       = row_w;
    assign bus.contact   = contact_w;
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
// Self-checking bench for keypad_emulator. A default-parameter instance and a
// no-bounce instance (HOLD=5, GAP=3) are exercised; with RANDOM_BOUNCE_EN a
// third instance (BOUNCE_PERIOD=8) checks randomised phase lengths.
// Expected envelopes are computed from cycle offsets after acceptance.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    keypad_emulator_if bus();
    keypad_emulator_if bus_nb();

    keypad_emulator u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    keypad_emulator #(
        .BOUNCE_TOGGLES (0),
        .HOLD_CYCLES    (5),
        .GAP_CYCLES     (3)
    ) u_dut_nb (
        .clock (clock),
        .reset (reset),
        .bus   (bus_nb)
    );

`ifdef RANDOM_BOUNCE_EN
    keypad_emulator_if bus_rb();

    keypad_emulator #(
        .BOUNCE_PERIOD (8),
        .HOLD_CYCLES   (20),
        .GAP_CYCLES    (10)
    ) u_dut_rb (
        .clock (clock),
        .reset (reset),
        .bus   (bus_rb)
    );
`endif

    typedef struct packed {
        logic [3:0] row;
        logic       contact;
        logic       ready;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic [3:0] key;
        logic [3:0] col;
        logic [3:0] row;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [3:0] rec_row   [0:1400];
    logic       rec_ready [0:1400];
    logic       rec_done  [0:1400];

    int runs[$];
    int runs_first[$];

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic obs_t rd(input int sel);
        obs_t o;
        case (sel)
            1:       o = '{bus_nb.row, bus_nb.contact, bus_nb.req_ready, bus_nb.busy, bus_nb.done};
`ifdef RANDOM_BOUNCE_EN
            2:       o = '{bus_rb.row, bus_rb.contact, bus_rb.req_ready, bus_rb.busy, bus_rb.done};
`endif
            default: o = '{bus.row, bus.contact, bus.req_ready, bus.busy, bus.done};
        endcase
        return o;
    endfunction

    task automatic drive_req(input int sel, input logic v, input logic [3:0] key);
        case (sel)
            1:       begin bus_nb.req_valid = v; bus_nb.req_keycode = key; end
`ifdef RANDOM_BOUNCE_EN
            2:       begin bus_rb.req_valid = v; bus_rb.req_keycode = key; end
`endif
            default: begin bus.req_valid = v; bus.req_keycode = key; end
        endcase
    endtask

    task automatic drive_col(input int sel, input logic [3:0] c);
        case (sel)
            1:       bus_nb.col = c;
`ifdef RANDOM_BOUNCE_EN
            2:       bus_rb.col = c;
`endif
            default: bus.col = c;
        endcase
    endtask

    // Reference envelope: contact state k cycles after acceptance.
    function automatic bit exp_contact(input int k, input int bt, input int bp,
                                       input int hold);
        int b;
        b = bt * bp;
        if (k >= 1 && k <= b)                    return ((k - 1) / bp) % 2 == 0;
        if (k > b && k <= b + hold)              return 1'b1;
        if (k > b + hold && k <= 2 * b + hold)   return ((k - 1 - b - hold) / bp) % 2 == 1;
        return 1'b0;
    endfunction

    // Reference switch matrix: closed key pulls its row low when its column is low.
    function automatic logic [3:0] exp_row(input bit c, input logic [3:0] key, input logic [3:0] col);
        logic [3:0] r;
        int kr, kc;
        r  = 4'b1111;
        kr = int'(key) / 4;
        kc = int'(key) % 4;
        if (c && col[kc] == 1'b0) r[kr] = 1'b0;
        return r;
    endfunction

    task automatic wait_ready(input int sel, input string name);
        int n;
        n = 0;
        while (!rd(sel).ready && n < 3000) begin
            tick();
            n++;
        end
        check({name, " ready wait"}, 32'(rd(sel).ready), 32'd1);
    endtask

    task automatic wait_done(input int sel, input string name);
        int n;
        n = 0;
        while (!rd(sel).done && n < 3000) begin
            tick();
            n++;
        end
        check({name, " done wait"}, 32'(rd(sel).done), 32'd1);
        tick();
    endtask

    // One full press checked every cycle against the reference envelope.
    task automatic run_press(input int sel, input logic [3:0] key, input logic [3:0] key_after,
                             input bit col_rand, input logic [3:0] col_fixed,
                             input bit keep_valid, input string name);
        int bt, bp, hold, gap, t, last;
        int e_row, e_con, e_rdy, e_done, first_bad;
        logic [3:0] colv;
        obs_t o;
        bit ec;
        if (sel == 1) begin bt = 0; bp = 16; hold = 5;    gap = 3;   end
        else          begin bt = 4; bp = 16; hold = 1000; gap = 200; end
        t = 2 * bt * bp + hold + gap;
        last = keep_valid ? t + 1 : t + 2;
        e_row = 0; e_con = 0; e_rdy = 0; e_done = 0; first_bad = 0;
        colv = col_fixed;

        wait_ready(sel, name);
        drive_req(sel, 1'b1, key);
        drive_col(sel, colv);
        tick();
        drive_req(sel, keep_valid, key_after);
        for (int k = 1; k <= last; k++) begin
            if (col_rand) colv = 4'($urandom);
            drive_col(sel, colv);
            #1;
            o  = rd(sel);
            ec = exp_contact(k, bt, bp, hold);
            rec_row[k]   = o.row;
            rec_ready[k] = o.ready;
            rec_done[k]  = o.done;
            if (o.row !== exp_row(ec, key, colv))          begin e_row++;  if (first_bad == 0) first_bad = k; end
            if (o.contact !== ec)                          begin e_con++;  if (first_bad == 0) first_bad = k; end
            if (o.ready !== (k > t) || o.busy !== (k <= t)) begin e_rdy++;  if (first_bad == 0) first_bad = k; end
            if (o.done !== (k == t + 1))                   begin e_done++; if (first_bad == 0) first_bad = k; end
            if (k < last) tick();
        end
        check($sformatf("%s row cycles (first bad %0d)", name, first_bad), e_row, 0);
        check($sformatf("%s contact cycles", name), e_con, 0);
        check($sformatf("%s ready/busy cycles", name), e_rdy, 0);
        check($sformatf("%s done cycles", name), e_done, 0);
    endtask

`ifdef RANDOM_BOUNCE_EN
    // Contact run lengths of one press on the random-bounce instance.
    task automatic collect_runs();
        int n, len;
        logic cur;
        runs.delete();
        wait_ready(2, "rb");
        drive_req(2, 1'b1, 4'h5);
        tick();
        drive_req(2, 1'b0, 4'h5);
        cur = rd(2).contact;
        len = 1;
        n = 0;
        tick();
        while (!rd(2).done && n < 2000) begin
            if (rd(2).contact == cur) len++;
            else begin runs.push_back(len); cur = rd(2).contact; len = 1; end
            tick();
            n++;
        end
        runs.push_back(len);
        check("rb done seen", 32'(rd(2).done), 32'd1);
    endtask
`endif

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        vec_t tbl[12];
        obs_t o;
        tbl = '{
            '{4'hF, 4'b1110, 4'b1111}, '{4'hF, 4'b1101, 4'b1111},
            '{4'hF, 4'b1011, 4'b1111}, '{4'hF, 4'b0111, 4'b0111},
            '{4'hF, 4'b0000, 4'b0111}, '{4'hF, 4'b1111, 4'b1111},
            '{4'h9, 4'b1101, 4'b1011}, '{4'h9, 4'b0101, 4'b1011},
            '{4'h9, 4'b1110, 4'b1111}, '{4'h6, 4'b1011, 4'b1101},
            '{4'h6, 4'b1001, 4'b1101}, '{4'h6, 4'b0100, 4'b1111}
        };

        reset = 1'b1;
        drive_req(0, 1'b0, 4'h0); drive_col(0, 4'hF);
        drive_req(1, 1'b0, 4'h0); drive_col(1, 4'hF);
`ifdef RANDOM_BOUNCE_EN
        drive_req(2, 1'b0, 4'h0); drive_col(2, 4'hF);
`endif
        repeat (3) tick();

        // Reset values on both instances.
        for (int s = 0; s < 2; s++) begin
            o = rd(s);
            check($sformatf("reset row %0d", s),     32'(o.row),     32'hF);
            check($sformatf("reset contact %0d", s), 32'(o.contact), 32'd0);
            check($sformatf("reset ready %0d", s),   32'(o.ready),   32'd1);
            check($sformatf("reset busy %0d", s),    32'(o.busy),    32'd0);
            check($sformatf("reset done %0d", s),    32'(o.done),    32'd0);
        end
        reset = 1'b0;
        tick();

`ifndef RANDOM_BOUNCE_EN
        // Single press, key 6, col 1011, with explicit boundary points.
        run_press(0, 4'h6, 4'h6, 1'b0, 4'b1011, 1'b0, "press6");
        check("press6 c1",    32'(rec_row[1]),    32'hD);
        check("press6 c16",   32'(rec_row[16]),   32'hD);
        check("press6 c17",   32'(rec_row[17]),   32'hF);
        check("press6 c32",   32'(rec_row[32]),   32'hF);
        check("press6 c33",   32'(rec_row[33]),   32'hD);
        check("press6 c49",   32'(rec_row[49]),   32'hF);
        check("press6 c65",   32'(rec_row[65]),   32'hD);
        check("press6 c1064", 32'(rec_row[1064]), 32'hD);
        check("press6 c1065", 32'(rec_row[1065]), 32'hF);
        check("press6 c1081", 32'(rec_row[1081]), 32'hD);
        check("press6 c1128", 32'(rec_row[1128]), 32'hD);
        check("press6 c1129", 32'(rec_row[1129]), 32'hF);
        check("press6 ready c1328", 32'(rec_ready[1328]), 32'd0);
        check("press6 ready c1329", 32'(rec_ready[1329]), 32'd1);
        check("press6 done c1328",  32'(rec_done[1328]),  32'd0);
        check("press6 done c1329",  32'(rec_done[1329]),  32'd1);
        check("press6 done c1330",  32'(rec_done[1330]),  32'd0);

        // Back-pressure: valid stays high, keycode changes after acceptance.
        run_press(0, 4'h1, 4'h2, 1'b0, 4'b1101, 1'b1, "bp key1");
        run_press(0, 4'h2, 4'h2, 1'b0, 4'b1011, 1'b0, "bp key2");

        // Random column drive on a random key.
        run_press(0, 4'($urandom), 4'($urandom), 1'b1, 4'hF, 1'b0, "rand dflt");
`endif

        // No-bounce instance: key 0, col 1110.
        run_press(1, 4'h0, 4'h0, 1'b0, 4'b1110, 1'b0, "nb");
        check("nb c1",       32'(rec_row[1]),   32'hE);
        check("nb c5",       32'(rec_row[5]),   32'hE);
        check("nb c6",       32'(rec_row[6]),   32'hF);
        check("nb ready c8", 32'(rec_ready[8]), 32'd0);
        check("nb ready c9", 32'(rec_ready[9]), 32'd1);
        for (int i = 0; i < 20; i++) begin
            run_press(1, 4'($urandom), 4'($urandom), 1'b1, 4'hF, 1'b0,
                      $sformatf("nb rand %0d", i));
        end

        // Column gating table, applied during HOLD of the default instance.
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || tbl[i].key != tbl[i-1].key) begin
                if (i != 0) wait_done(0, "table");
                wait_ready(0, "table");
                drive_req(0, 1'b1, tbl[i].key);
                tick();
                drive_req(0, 1'b0, tbl[i].key);
                repeat (69) tick();
            end
            drive_col(0, tbl[i].col);
            #1;
            check($sformatf("table %0d key %0h col %b", i, tbl[i].key, tbl[i].col),
                  32'(rd(0).row), 32'(tbl[i].row));
            tick();
        end
        wait_done(0, "table");

        // Reset in the middle of HOLD releases everything before any edge.
        drive_col(0, 4'b1011);
        wait_ready(0, "rst");
        drive_req(0, 1'b1, 4'h6);
        tick();
        drive_req(0, 1'b0, 4'h6);
        repeat (99) tick();
        check("rst pre row", 32'(rd(0).row), 32'hD);
        reset = 1'b1;
        #1;
        o = rd(0);
        check("rst row",     32'(o.row),     32'hF);
        check("rst contact", 32'(o.contact), 32'd0);
        check("rst ready",   32'(o.ready),   32'd1);
        check("rst busy",    32'(o.busy),    32'd0);
        tick();
        reset = 1'b0;
        tick();

`ifdef RANDOM_BOUNCE_EN
        // Random bounce: 4 phases per burst, each 1..8, repeatable after reset.
        begin
            int bad;
            collect_runs();
            runs_first = runs;
            check("rb run count", runs.size(), 10);
            if (runs.size() == 10) begin
                bad = 0;
                for (int i = 0; i < 10; i++) begin
                    if (i != 4 && i != 9 && (runs[i] < 1 || runs[i] > 8)) bad++;
                end
                check("rb phase range", bad, 0);
                check("rb hold len", runs[4], 20);
                check("rb gap len",  runs[9], 10);
            end
            reset = 1'b1;
            tick();
            reset = 1'b0;
            tick();
            collect_runs();
            check("rb repeat count", runs.size(), runs_first.size());
            bad = 0;
            for (int i = 0; i < runs.size() && i < runs_first.size(); i++) begin
                if (runs[i] != runs_first[i]) bad++;
            end
            check("rb repeat lengths", bad, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable 4x4 matrix-keypad responder: the passive keypad end of the scan interface that keypadscanner initiates. It accepts key-press requests through a valid/ready handshake and drives ROW in response to the scanned COL. Each press follows a timed contact envelope: bounce in, hold, bounce out, then a release gap. Used for hardware-in-loop exercise of the scanner, debouncer and input-handler chain from switches or a test sequencer, in place of the physical keypad.

Parameters:
HOLD_CYCLES, 1000, cycles contact is held solidly closed (>=1)
BOUNCE_TOGGLES, 4, contact phases per bounce burst; must be even; 0 disables bounce
BOUNCE_PERIOD, 16, cycles per bounce phase (>=1)
GAP_CYCLES, 200, open-contact cycles after release before next request accepted (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  press request valid
req_ready  out  1  emulator idle, can accept request
req_keycode  in  4  [3:2]=row index, [1:0]=column index
col  in  4  column drive from scanner, active-low
row  out  4  row return to scanner, active-low, idle 4'b1111
contact  out  1  current simulated switch closure (debug/LED)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when GAP ends

Behaviour:
- One clock; reset is asynchronous and active-high; all state is clocked on clock.
- Reset values: state=IDLE, contact=0, row=4'b1111, req_ready=1, busy=0, done=0, latched key=0, counters=0.
- Handshake: accept when req_valid && req_ready in IDLE; latch req_keycode that cycle. req_ready=1 only in IDLE. A request held valid while busy is ignored until IDLE.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE -> BOUNCE_IN on accept (HOLD directly if BOUNCE_TOGGLES=0).
- BOUNCE_IN: BOUNCE_TOGGLES phases of BOUNCE_PERIOD cycles each. Contact=1 in even phases, 0 in odd phases. Then -> HOLD.
- HOLD: contact=1 for HOLD_CYCLES. Then -> BOUNCE_OUT (GAP if no bounce).
- BOUNCE_OUT: same phase count; contact=0 in even phases, 1 in odd phases. Then -> GAP.
- GAP: contact=0 for GAP_CYCLES. Then -> IDLE with done=1 for exactly one cycle.
- Timing: first contact=1 cycle is the cycle after acceptance. req_ready reasserts 1+2*BOUNCE_TOGGLES*BOUNCE_PERIOD+HOLD_CYCLES+GAP_CYCLES cycles after acceptance.
- Row function (combinational from col, contact, latched key): row[r]=0 iff contact && r==key_row && col[key_col]==0; all other bits 1.
- Multiple columns low: the row still asserts when the key column is among them. col=4'b1111 gives row=4'b1111.
- Counters sized by $clog2 of the maximum parameter. They must not wrap within a state.
- Reset mid-press: immediate return to reset values; row releases asynchronously.

Optional Feature:
RANDOM_BOUNCE_EN
- Defined: each bounce phase length = 1 + (lfsr[3:0] mod BOUNCE_PERIOD). Uses an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5 on reset, stepped once per phase start. Phase count, HOLD and GAP timing unchanged.
- Undefined: fixed BOUNCE_PERIOD phases as above; no LFSR logic synthesized.

Decomposition:
- Package keypad_pkg: state enum, KEY_ROW/KEY_COL field positions, ROW_IDLE=4'b1111, LFSR seed and tap constants.
- Sub-module lfsr8 (enable, seed load, 8-bit state), instantiated only under RANDOM_BOUNCE_EN. The FSM and row logic stay in keypad_emulator.

Test Plan:
- Reset: assert reset mid-HOLD with key 4'h6 and col=4'b1011 -> row=4'b1111, contact=0, req_ready=1 immediately, before the next clock edge.
- Single press, defaults, key 4'h6 (row1,col2), col held 4'b1011:
  - row=4'b1101 for cycles 1-16 and 33-48 after accept, 1111 for cycles 17-32.
  - Solid 1101 for 1000 HOLD cycles; bounce-out mirrors bounce-in.
  - done pulses and req_ready=1 exactly 1+128+1000+200=1329 cycles after accept.
- Column gating: key 4'hF pressed, col sweeps 1110, 1101, 1011, 0111 -> row=4'b0111 only while col=0111; otherwise 1111.
- Back-pressure: req_valid held high with keys 4'h1 then 4'h2 -> second accepted only after done; 4'h1 envelope unaffected by the keycode change.
- No bounce: BOUNCE_TOGGLES=0, HOLD_CYCLES=5, GAP_CYCLES=3, key 4'h0, col=4'b1110 -> row=4'b1110 for exactly cycles 1-5; ready again at cycle 9.
- RANDOM_BOUNCE_EN: BOUNCE_PERIOD=8 -> every bounce phase length is within 1..8. Sequence is repeatable after reset (seed A5), and 4 phases are observed per burst.
